apu_sample_fetch: RTL
=====================

// Module: apu_sample_fetch
// PURPOSE
//  Avalon-MM burst-read master on the HPS f2h_sdram0 port. Fetches audio sample buffers from SDRAM into an
//  on-chip FIFO and streams 16-bit samples to the APU mixer. Each transfer is started by a write to the APU
//  control PIO (valid/data pair). Sits between the SoC's apu_control/f2h_sdram0 exports and the APU core.
// PARAMETERS
//  BURST_LEN   8    64-bit beats per Avalon burst (1..128). BUF_WORDS must be a multiple of it.
//  BUF_WORDS   128  64-bit words per buffer fetch (= 4*BUF_WORDS samples).
//  FIFO_DEPTH  32   64-bit word FIFO entries; power of 2, >= BURST_LEN.
// PORTS
//  clk                 in   1   system clock (same clock as the SoC fabric)
//  rst_n               in   1   asynchronous active-low reset
//  cmd_valid           in   1   1-cycle strobe from apu_control PIO
//  cmd_data            in   32  byte address of buffer; bits [2:0] ignored
//  avm_address         out  29  SDRAM word address (64-bit words) = byte addr [31:3]
//  avm_burstcount      out  8   constant BURST_LEN
//  avm_read            out  1   read request
//  avm_waitrequest     in   1   slave stall
//  avm_readdata        in   64  read beat data
//  avm_readdatavalid   in   1   read beat valid
//  samp_valid          out  1   sample available
//  samp_data           out  16  signed PCM sample
//  samp_ready          in   1   APU consumes sample when valid&ready
//  busy                out  1   fetch in progress (state != IDLE)
//  buf_done            out  1   1-cycle pulse: last beat of buffer written to FIFO
// BEHAVIOUR
//  Reset: avm_read=0, avm_address=0, samp_valid=0, samp_data=0, busy=0, buf_done=0; FIFO empty, pending cleared.
//  FSM: IDLE, REQ, BEATS.
//   IDLE : on cmd_valid (or pending cmd) latch word addr, beats_left=BUF_WORDS; go REQ when FIFO free
//          space >= BURST_LEN, otherwise wait in IDLE with busy=1.
//   REQ  : avm_read=1, address/burstcount held stable until cycle with avm_waitrequest=0; then read=0, go BEATS.
//   BEATS: each avm_readdatavalid writes readdata to FIFO, beats_left--. After BURST_LEN beats: addr+=BURST_LEN;
//          if beats_left==0 pulse buf_done, go IDLE; else go REQ once free space >= BURST_LEN, else stall.
//  One burst outstanding max; free-space check guarantees FIFO never overflows (write when full = bug, assert).
//  Address arithmetic modulo 2^29 (wraps past top of SDRAM, no error).
//  cmd_valid while busy: stored in one-deep pending slot (newest wins), started on return to IDLE;
//   never aborts the current buffer. cmd_valid same cycle as buf_done: becomes the next buffer, no loss.
//  Sample output: FIFO head word split into 4 samples, order [15:0],[31:16],[47:32],[63:48]; word popped
//   after 4th sample accepted. samp_data/samp_valid registered; first sample 2 cycles after its beat enters FIFO.
//  samp_valid held with stable data until samp_ready; FIFO empty -> samp_valid=0 (APU underruns, no repeat).
//  Simultaneous FIFO write and pop in one cycle allowed at any occupancy incl. full/empty.
//  Reset mid-burst: all state cleared asynchronously; SoC shares rst_n so no stale beats arrive after reset.
// TESTING
//  1 cmd 0x0000_1000, waitrequest=0, beats 1/cycle -> 16 bursts, addrs 0x200,0x208..0x278, buf_done once
//    after 128th beat; samples read in order [15:0] first.
//  2 waitrequest held 5 cycles in REQ -> avm_read/address/burstcount stable all 5 cycles, one accepted request.
//  3 samp_ready=0 throughout, cmd issued -> exactly 4 bursts (32 words) then FSM stalls, no overflow;
//    raise samp_ready -> fetch resumes, all 512 samples delivered in order.
//  4 second cmd 0x2000 then third 0x3000 while busy -> after first buf_done, fetch starts at word 0x600 only.
//  5 cmd 0xFFFF_FFC0 -> addresses 0x1FFF_FFF8 then wrap to 0x0000_0000.
//  6 rst_n low mid-BEATS -> all outputs 0 immediately; new cmd after release fetches cleanly.

Source files
------------

// File: rtl/apu_sample_fetch.sv
// Avalon-MM burst-read master: fetches sample buffers from SDRAM into a word FIFO
// and streams them to the APU mixer as 16-bit PCM samples, low half-word first.
module apu_sample_fetch #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned BUF_WORDS  = 128,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic [28:0] avm_address,
  output logic [7:0]  avm_burstcount,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [63:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        samp_valid,
  output logic [15:0] samp_data,
  input  logic        samp_ready,
  output logic        busy,
  output logic        buf_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BL_W  = $clog2(BUF_WORDS + 1);
  localparam int unsigned BC_W  = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] FILL_LIMIT = CNT_W'(FIFO_DEPTH - BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEATS
  } state_e;

  state_e            state_q, state_d;
  logic [28:0]       addr_q, addr_d;
  logic [BL_W-1:0]   beats_left_q, beats_left_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic [28:0]       pend_addr_q, pend_addr_d;
  logic              avm_read_q, avm_read_d;
  logic              busy_q, busy_d;
  logic              buf_done_q, buf_done_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [63:0]       fifo_mem [FIFO_DEPTH];

  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_data_q, out_data_d;
  logic [1:0]        out_idx_q, out_idx_d;

  logic              room;
  logic              burst_done;
  logic              push;
  logic              pop;
  logic [63:0]       head_word;
  logic [63:0]       next_word;
  logic              unused_cmd_lsbs;

  assign unused_cmd_lsbs = ^cmd_data[2:0];

  // No burst is ever in flight when room is evaluated, so count_q is exact.
  assign room       = (count_q <= FILL_LIMIT);
  assign burst_done = (beat_cnt_q == BC_W'(BURST_LEN));
  assign push       = (state_q == ST_BEATS) && avm_readdatavalid && !burst_done;
  assign pop        = out_valid_q && samp_ready && (out_idx_q == 2'd3);
  assign head_word  = fifo_mem[rd_ptr_q];
  assign next_word  = fifo_mem[rd_ptr_q + PTR_W'(1)];

  function automatic logic [15:0] pick_sample(input logic [63:0] w, input logic [1:0] idx);
    logic [15:0] s;
    unique case (idx)
      2'd0:    s = w[15:0];
      2'd1:    s = w[31:16];
      2'd2:    s = w[47:32];
      default: s = w[63:48];
    endcase
    return s;
  endfunction

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    beat_cnt_d   = beat_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    buf_done_d   = 1'b0;

    if (cmd_valid) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = cmd_data[31:3];
    end

    unique case (state_q)
      ST_IDLE: begin
        if ((cmd_valid || pend_valid_q) && room) begin
          addr_d       = cmd_valid ? cmd_data[31:3] : pend_addr_q;
          beats_left_d = BL_W'(BUF_WORDS);
          beat_cnt_d   = '0;
          pend_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          state_d = ST_BEATS;
        end
      end
      ST_BEATS: begin
        // After the final beat of a burst, beat_cnt parks at BURST_LEN until room frees.
        if (burst_done) begin
          if (room) begin
            beat_cnt_d = '0;
            state_d    = ST_REQ;
          end
        end else if (avm_readdatavalid) begin
          beats_left_d = beats_left_q - BL_W'(1);
          beat_cnt_d   = beat_cnt_q + BC_W'(1);
          if (beat_cnt_q == BC_W'(BURST_LEN - 1)) begin
            addr_d = addr_q + 29'(BURST_LEN);
            if (beats_left_q == BL_W'(1)) begin
              buf_done_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    avm_read_d = (state_d == ST_REQ);
    busy_d     = (state_d != ST_IDLE) || pend_valid_d;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // The head word stays in the FIFO until its 4th sample is accepted; the next
  // word is read one slot ahead so back-to-back words stream without a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    if (!out_valid_q) begin
      if (count_q != '0) begin
        out_valid_d = 1'b1;
        out_idx_d   = 2'd0;
        out_data_d  = pick_sample(head_word, 2'd0);
      end
    end else if (samp_ready) begin
      if (out_idx_q == 2'd3) begin
        if (count_q >= CNT_W'(2)) begin
          out_idx_d  = 2'd0;
          out_data_d = pick_sample(next_word, 2'd0);
        end else begin
          out_valid_d = 1'b0;
        end
      end else begin
        out_idx_d  = out_idx_q + 2'd1;
        out_data_d = pick_sample(head_word, out_idx_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      beat_cnt_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      avm_read_q   <= 1'b0;
      busy_q       <= 1'b0;
      buf_done_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      beat_cnt_q   <= beat_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      avm_read_q   <= avm_read_d;
      busy_q       <= busy_d;
      buf_done_q   <= buf_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= avm_readdata;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

  assign avm_address    = addr_q;
  assign avm_burstcount = 8'(BURST_LEN);
  assign avm_read       = avm_read_q;
  assign samp_valid     = out_valid_q;
  assign samp_data      = out_data_q;
  assign busy           = busy_q;
  assign buf_done       = buf_done_q;

endmodule
